// File: rtl/song_sequencer.sv
// Game-flow controller: countdown, note fetch/decode from a synchronous ROM,
// per-note hit windowing and per-song statistics.
module song_sequencer #(
    parameter int unsigned TICKS_PER_BEAT  = 6_250_000,
    parameter int unsigned COUNTDOWN_BEATS = 4,
    parameter int unsigned ADDR_W          = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              hit,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [3:0]        correct_note,
    output logic              note_valid,
    output logic              beat_pulse,
    output logic [2:0]        state,
    output logic [7:0]        streak,
    output logic [7:0]        max_streak,
    output logic [ADDR_W:0]   notes_hit,
    output logic [ADDR_W:0]   notes_total,
    output logic              song_done
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_FETCH     = 3'd2,
        S_DECODE    = 3'd3,
        S_PLAY      = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    localparam int unsigned LEN_MAX = ((COUNTDOWN_BEATS > 15) ? COUNTDOWN_BEATS : 15) * TICKS_PER_BEAT;
    localparam int unsigned LEN_W   = $clog2(LEN_MAX + 1);
    localparam int unsigned TICK_W  = $clog2(TICKS_PER_BEAT);
    localparam int unsigned STAT_W  = ADDR_W + 1;

    localparam logic [LEN_W-1:0]  CD_LEN    = LEN_W'(COUNTDOWN_BEATS * TICKS_PER_BEAT - 1);
    localparam logic [LEN_W-1:0]  TPB_LEN   = LEN_W'(TICKS_PER_BEAT);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BEAT - 1);

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [3:0]          note_q, note_d;
    logic                valid_q, valid_d;
    logic                flag_q, flag_d;
    logic [7:0]          streak_q, streak_d;
    logic [7:0]          max_q, max_d;
    logic [STAT_W-1:0]   hits_q, hits_d;
    logic [STAT_W-1:0]   total_q, total_d;
    logic                done_q, done_d;

    logic                start_song;
    logic [3:0]          code;
    logic [3:0]          dur;
    logic [7:0]          streak_inc;

    assign code       = rom_data[7:4];
    assign dur        = (rom_data[3:0] == 4'd0) ? 4'd1 : rom_data[3:0];
    assign streak_inc = (streak_q == 8'hFF) ? 8'hFF : streak_q + 8'd1;

    always_comb begin
        state_d    = state_q;
        tick_d     = tick_q;
        len_d      = len_q;
        addr_d     = addr_q;
        note_d     = note_q;
        valid_d    = valid_q;
        flag_d     = flag_q;
        streak_d   = streak_q;
        max_d      = max_q;
        hits_d     = hits_q;
        total_d    = total_q;
        done_d     = 1'b0;
        start_song = 1'b0;

        if (state_q == S_COUNTDOWN || state_q == S_PLAY) begin
            tick_d = (tick_q == TICK_LAST) ? '0 : tick_q + TICK_W'(1);
            len_d  = len_q - LEN_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) start_song = 1'b1;
            end
            S_COUNTDOWN: begin
                if (len_q == '0) state_d = S_FETCH;
            end
            S_FETCH: begin
                note_d  = '0;
                valid_d = 1'b0;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (code == 4'hF) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_PLAY;
                    note_d  = code;
                    valid_d = (code != 4'd0);
                    flag_d  = 1'b0;
                    tick_d  = '0;
                    len_d   = LEN_W'(dur) * TPB_LEN - LEN_W'(1);
                end
            end
            S_PLAY: begin
                if (hit && valid_q) flag_d = 1'b1;
                if (len_q == '0) begin
                    note_d  = '0;
                    valid_d = 1'b0;
                    // A hit on the final cycle is folded in directly, since the flag
                    // would only become visible after the note has already closed.
                    if (valid_q) begin
                        total_d = total_q + STAT_W'(1);
                        if (flag_q || hit) begin
                            hits_d   = hits_q + STAT_W'(1);
                            streak_d = streak_inc;
                            max_d    = (streak_inc > max_q) ? streak_inc : max_q;
                        end else begin
                            streak_d = '0;
                        end
                    end
                    if (addr_q == '1) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                if (start) start_song = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        if (start_song) begin
            state_d  = S_COUNTDOWN;
            tick_d   = '0;
            len_d    = CD_LEN;
            addr_d   = '0;
            note_d   = '0;
            valid_d  = 1'b0;
            flag_d   = 1'b0;
            streak_d = '0;
            max_d    = '0;
            hits_d   = '0;
            total_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            tick_q   <= '0;
            len_q    <= '0;
            addr_q   <= '0;
            note_q   <= '0;
            valid_q  <= 1'b0;
            flag_q   <= 1'b0;
            streak_q <= '0;
            max_q    <= '0;
            hits_q   <= '0;
            total_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            tick_q   <= tick_d;
            len_q    <= len_d;
            addr_q   <= addr_d;
            note_q   <= note_d;
            valid_q  <= valid_d;
            flag_q   <= flag_d;
            streak_q <= streak_d;
            max_q    <= max_d;
            hits_q   <= hits_d;
            total_q  <= total_d;
            done_q   <= done_d;
        end
    end

    assign rom_addr     = addr_q;
    assign correct_note = note_q;
    assign note_valid   = valid_q;
    assign beat_pulse   = (state_q == S_COUNTDOWN || state_q == S_PLAY) && (tick_q == TICK_LAST);
    assign state        = state_q;
    assign streak       = streak_q;
    assign max_streak   = max_q;
    assign notes_hit    = hits_q;
    assign notes_total  = total_q;
    assign song_done    = done_q;

endmodule

// File: tb/tb_song_sequencer.sv
// Directed bench for song_sequencer with TICKS_PER_BEAT=4, COUNTDOWN_BEATS=2;
// a second instance with ADDR_W=2 covers the end-of-ROM case.
module tb_song_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start, hit, start2, hit2;

    logic [7:0] rom_addr1;
    logic [7:0] rom_data1;
    logic [3:0] correct_note1;
    logic       note_valid1, beat_pulse1, song_done1;
    logic [2:0] state1;
    logic [7:0] streak1, max_streak1;
    logic [8:0] notes_hit1, notes_total1;

    logic [1:0] rom_addr2;
    logic [7:0] rom_data2;
    logic [3:0] correct_note2;
    logic       note_valid2, beat_pulse2, song_done2;
    logic [2:0] state2;
    logic [7:0] streak2, max_streak2;
    logic [2:0] notes_hit2, notes_total2;

    logic [7:0] rom1 [0:255];
    logic [7:0] rom2 [0:3];

    always @(posedge clk) rom_data1 <= rom1[rom_addr1];
    always @(posedge clk) rom_data2 <= rom2[rom_addr2];

    song_sequencer #(.TICKS_PER_BEAT(4), .COUNTDOWN_BEATS(2), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .start(start), .hit(hit),
        .rom_addr(rom_addr1), .rom_data(rom_data1),
        .correct_note(correct_note1), .note_valid(note_valid1),
        .beat_pulse(beat_pulse1), .state(state1),
        .streak(streak1), .max_streak(max_streak1),
        .notes_hit(notes_hit1), .notes_total(notes_total1),
        .song_done(song_done1)
    );

    song_sequencer #(.TICKS_PER_BEAT(4), .COUNTDOWN_BEATS(2), .ADDR_W(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .hit(hit2),
        .rom_addr(rom_addr2), .rom_data(rom_data2),
        .correct_note(correct_note2), .note_valid(note_valid2),
        .beat_pulse(beat_pulse2), .state(state2),
        .streak(streak2), .max_streak(max_streak2),
        .notes_hit(notes_hit2), .notes_total(notes_total2),
        .song_done(song_done2)
    );

    int checks = 0;
    int errors = 0;

    int st [64];
    int cn [64];
    int nv [64];
    int bp [64];
    int sd [64];
    int nh [64];
    int nt [64];
    int sk [64];
    int ms [64];
    int ra [64];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Records one observation per cycle; hmask/smask bit i drives hit/start during cycle i.
    task automatic run(input bit sel, input logic [63:0] hmask, input logic [63:0] smask, input int n);
        for (int i = 0; i < n; i++) begin
            if (!sel) begin
                st[i] = int'(state1);       cn[i] = int'(correct_note1);
                nv[i] = int'(note_valid1);  bp[i] = int'(beat_pulse1);
                sd[i] = int'(song_done1);   nh[i] = int'(notes_hit1);
                nt[i] = int'(notes_total1); sk[i] = int'(streak1);
                ms[i] = int'(max_streak1);  ra[i] = int'(rom_addr1);
            end else begin
                st[i] = int'(state2);       cn[i] = int'(correct_note2);
                nv[i] = int'(note_valid2);  bp[i] = int'(beat_pulse2);
                sd[i] = int'(song_done2);   nh[i] = int'(notes_hit2);
                nt[i] = int'(notes_total2); sk[i] = int'(streak2);
                ms[i] = int'(max_streak2);  ra[i] = int'(rom_addr2);
            end
            hit   = hmask[i];
            start = smask[i];
            step();
        end
        hit   = 1'b0;
        start = 1'b0;
    endtask

    function automatic int count_eq(input int arr [64], input int lo, input int hi, input int val);
        int c = 0;
        for (int i = lo; i <= hi; i++) if (arr[i] == val) c++;
        return c;
    endfunction

    function automatic logic [63:0] bit_at(input int i);
        logic [63:0] one = 64'd1;
        return one << i;
    endfunction

    task automatic start_dut1();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; hit = 1'b0; start2 = 1'b0; hit2 = 1'b0;
        for (int i = 0; i < 256; i++) rom1[i] = 8'hF0;
        for (int i = 0; i < 4; i++) rom2[i] = 8'hF0;
        step();
        step();

        check("rst_state", int'(state1), 0);
        check("rst_note", int'(correct_note1), 0);
        check("rst_valid", int'(note_valid1), 0);
        check("rst_beat", int'(beat_pulse1), 0);
        check("rst_addr", int'(rom_addr1), 0);
        check("rst_stats", int'(notes_hit1) + int'(notes_total1) + int'(streak1) + int'(max_streak1), 0);
        check("rst_done", int'(song_done1), 0);
        check("rst_state2", int'(state2), 0);
        reset = 1'b0;
        step();
        check("idle_hold", int'(state1), 0);

        // Basic song: {51,32,F0}, no hits
        rom1[0] = 8'h51; rom1[1] = 8'h32; rom1[2] = 8'hF0;
        start_dut1();
        check("start_latency", int'(state1), 1);
        run(1'b0, '0, '0, 30);
        check("cd_beats", count_eq(bp, 0, 7, 1), 2);
        check("cd_state", count_eq(st, 0, 7, 1), 8);
        check("first_note_lat", count_eq(nv, 0, 9, 1) + 10 * nv[10], 10);
        check("note5_len", count_eq(cn, 0, 29, 5), 4);
        check("gap_cycles", count_eq(nv, 14, 15, 0) + count_eq(st, 14, 14, 2) + count_eq(st, 15, 15, 3), 4);
        check("note3_len", count_eq(cn, 0, 29, 3), 8);
        check("play_beats", count_eq(bp, 16, 23, 1), 2);
        check("basic_done_state", st[26], 5);
        check("basic_done_pulse", count_eq(sd, 0, 29, 1), 1);
        check("basic_done_at", sd[26], 1);
        check("basic_total", nt[29], 2);
        check("basic_hit", nh[29], 0);
        check("basic_streak", sk[29], 0);

        // Hits and streaks: {51,31,31,31,F0}; hits in notes 1 (x3), 2 (final cycle), 4
        rom1[0] = 8'h51; rom1[1] = 8'h31; rom1[2] = 8'h31; rom1[3] = 8'h31; rom1[4] = 8'hF0;
        start_dut1();
        check("restart_state", int'(state1), 1);
        check("restart_total", int'(notes_total1), 0);
        check("restart_addr", int'(rom_addr1), 0);
        run(1'b0, bit_at(10) | bit_at(11) | bit_at(12) | bit_at(19) | bit_at(29), '0, 36);
        check("n1_hit_once", nh[14], 1);
        check("n2_final_hit", nh[20], 2);
        check("n2_streak", sk[20], 2);
        check("n2_max", ms[20], 2);
        check("n3_miss_streak", sk[26], 0);
        check("n3_max_held", ms[26], 2);
        check("n4_streak", sk[32], 1);
        check("hs_done", st[34], 5);
        check("hs_hits", nh[35], 3);
        check("hs_total", nt[35], 4);
        check("hs_streak", sk[35], 1);
        check("hs_max", ms[35], 2);

        // Rest: {51,02,31,F0}; hit during the rest is ignored
        rom1[0] = 8'h51; rom1[1] = 8'h02; rom1[2] = 8'h31; rom1[3] = 8'hF0;
        start_dut1();
        check("restart2_stats", int'(streak1) + int'(max_streak1) + int'(notes_hit1) + int'(notes_total1), 0);
        check("restart2_addr", int'(rom_addr1), 0);
        run(1'b0, bit_at(11) | bit_at(18) | bit_at(27), '0, 34);
        check("rest_invalid", count_eq(nv, 16, 23, 0), 8);
        check("rest_play", count_eq(st, 16, 23, 4), 8);
        check("rest_no_stats", nt[24], 1);
        check("n3_valid", nv[26], 1);
        check("rest_done", st[32], 5);
        check("rest_streak", sk[33], 2);
        check("rest_total", nt[33], 2);
        check("rest_hits", nh[33], 2);

        // start during PLAY is ignored
        rom1[0] = 8'h51; rom1[1] = 8'h32; rom1[2] = 8'hF0;
        start_dut1();
        run(1'b0, bit_at(11), bit_at(12), 30);
        check("ign_start_state", st[13], 4);
        check("ign_start_note", count_eq(cn, 0, 29, 5), 4);
        check("ign_start_done", st[26], 5);
        check("ign_start_total", nt[29], 2);
        check("ign_start_hits", nh[29], 1);

        // reset mid-PLAY
        start_dut1();
        run(1'b0, bit_at(11), '0, 18);
        check("pre_rst_play", int'(state1), 4);
        check("pre_rst_hits", int'(notes_hit1), 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_rst_state", int'(state1), 0);
        check("mid_rst_note", int'(correct_note1) + int'(note_valid1) + int'(beat_pulse1), 0);
        check("mid_rst_stats", int'(notes_hit1) + int'(notes_total1) + int'(streak1) + int'(max_streak1), 0);
        check("mid_rst_addr", int'(rom_addr1), 0);

        // ROM end without marker, ADDR_W=2: {10,21,31,41}
        rom2[0] = 8'h10; rom2[1] = 8'h21; rom2[2] = 8'h31; rom2[3] = 8'h41;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        check("w2_start", int'(state2), 1);
        run(1'b1, '0, '0, 36);
        check("w2_dur0", count_eq(cn, 0, 35, 1), 4);
        check("w2_note4", count_eq(cn, 0, 35, 4), 4);
        check("w2_last_play", st[31], 4);
        check("w2_done", st[32], 5);
        check("w2_addr_stay", ra[32] + ra[35], 6);
        check("w2_total", nt[35], 4);
        check("w2_done_pulse", count_eq(sd, 0, 35, 1), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
